regfile_sb: RTL and testbench

- Parametrised successor to the CPU's 4x8 register file.
- Generalised in data width, register count and number of read ports.
- Adds a post-reset clearing sweep with a ready flag, and a per-register busy scoreboard for pending writebacks.
- Sits between decode (reads and issue) and writeback (write) in the CPU datapath.

---
 rtl/cpu_regfile_pkg.sv | 20 ++
 rtl/regfile_scoreboard.sv | 35 +++
 rtl/regfile_sb.sv | 120 ++++++++++++
 tb/tb_regfile_sb.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/cpu_regfile_pkg.sv
// Shared types and helpers for the register file with scoreboard.
package cpu_regfile_pkg;

  typedef enum logic {
    ST_INIT,
    ST_RUN
  } state_t;

  localparam int DEF_DATA_W   = 8;
  localparam int DEF_NUM_REGS = 4;
  localparam int DEF_ADDR_W   = 3;

  // Upper address bits alias onto the physical registers.
  function automatic logic [4:0] idx_of(input logic [31:0] addr, input int idx_w);
    logic [31:0] mask;
    mask = (32'd1 << idx_w) - 32'd1;
    return 5'(addr & mask);
  endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// Per-register busy bits: set on issue, cleared on writeback, with one lookup per read port.
module regfile_scoreboard
  import cpu_regfile_pkg::*;
#(
  parameter int NUM_REGS = DEF_NUM_REGS,
  parameter int IDX_W    = $clog2(NUM_REGS),
  parameter int NUM_RD   = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      set_en,
  input  logic [IDX_W-1:0]          set_idx,
  input  logic                      clr_en,
  input  logic [IDX_W-1:0]          clr_idx,
  input  logic [NUM_RD*IDX_W-1:0]   look_idx,
  output logic [NUM_RD-1:0]         look_busy
);

  logic [NUM_REGS-1:0] busy;

  // Set is applied after clear so a new producer wins over a writeback to the same register.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy <= '0;
    end else begin
      if (clr_en) busy[clr_idx] <= 1'b0;
      if (set_en) busy[set_idx] <= 1'b1;
    end
  end

  for (genvar g = 0; g < NUM_RD; g++) begin : g_look
    assign look_busy[g] = busy[look_idx[g*IDX_W +: IDX_W]];
  end

endmodule

// File: rtl/regfile_sb.sv
// Parametrised register file with post-reset clearing sweep and busy scoreboard.
// Optional REGFILE_ZERO_REG_EN hardwires index 0 to zero.
module regfile_sb
  import cpu_regfile_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int NUM_REGS = DEF_NUM_REGS,
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int NUM_RD   = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  output logic                     ready,
  input  logic                     wr_en,
  input  logic [ADDR_W-1:0]        wr_addr,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic                     iss_en,
  input  logic [ADDR_W-1:0]        iss_addr,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  output logic [NUM_RD-1:0]        rd_busy
);

  localparam int IDX_W = $clog2(NUM_REGS);
`ifdef REGFILE_ZERO_REG_EN
  localparam bit ZERO_REG = 1'b1;
`else
  localparam bit ZERO_REG = 1'b0;
`endif

  state_t             state;
  logic [IDX_W:0]     cnt;
  logic [DATA_W-1:0]  regs [NUM_REGS];

  logic               run;
  logic [IDX_W-1:0]   wr_idx;
  logic [IDX_W-1:0]   iss_idx;
  logic               wr_ok;
  logic               iss_ok;
  logic [NUM_RD*IDX_W-1:0] rd_idx;
  logic [NUM_RD-1:0]  sb_busy;

  assign run     = (state == ST_RUN);
  assign wr_idx  = IDX_W'(idx_of(32'(wr_addr), IDX_W));
  assign iss_idx = IDX_W'(idx_of(32'(iss_addr), IDX_W));
  assign wr_ok   = run && wr_en  && !(ZERO_REG && (wr_idx  == '0));
  assign iss_ok  = run && iss_en && !(ZERO_REG && (iss_idx == '0));

  // Sweep FSM; cnt is one bit wider than the index so the terminal compare never wraps.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_INIT;
      cnt   <= '0;
      ready <= 1'b0;
    end else begin
      case (state)
        ST_INIT: begin
          cnt <= cnt + 1'b1;
          if (cnt == (IDX_W+1)'(NUM_REGS - 1)) begin
            state <= ST_RUN;
            ready <= 1'b1;
          end
        end
        ST_RUN: begin
          state <= ST_RUN;
          ready <= 1'b1;
        end
        default: begin
          state <= ST_INIT;
          cnt   <= '0;
          ready <= 1'b0;
        end
      endcase
    end
  end

  // Storage has no reset of its own; the sweep clears it one register per cycle.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (state == ST_INIT) begin
        regs[cnt[IDX_W-1:0]] <= '0;
      end else if (wr_ok) begin
        regs[wr_idx] <= wr_data;
      end
    end
  end

  regfile_scoreboard #(
    .NUM_REGS (NUM_REGS),
    .IDX_W    (IDX_W),
    .NUM_RD   (NUM_RD)
  ) u_sb (
    .clk       (clk),
    .rst       (rst),
    .set_en    (iss_ok),
    .set_idx   (iss_idx),
    .clr_en    (wr_ok),
    .clr_idx   (wr_idx),
    .look_idx  (rd_idx),
    .look_busy (sb_busy)
  );

  // Zero-latency read ports with writeback forwarding.
  for (genvar g = 0; g < NUM_RD; g++) begin : g_rd
    logic [IDX_W-1:0] ri;
    logic             hit;
    logic             zero_idx;

    assign ri       = IDX_W'(idx_of(32'(rd_addr[g*ADDR_W +: ADDR_W]), IDX_W));
    assign rd_idx[g*IDX_W +: IDX_W] = ri;
    assign hit      = wr_ok && (wr_idx == ri);
    assign zero_idx = ZERO_REG && (ri == '0);

    assign rd_data[g*DATA_W +: DATA_W] = (!run || zero_idx) ? '0 :
                                         hit                ? wr_data :
                                                              regs[ri];
    assign rd_busy[g] = run && !zero_idx && sb_busy[g] && !hit;
  end

endmodule

// File: tb/tb_regfile_sb.sv
// Directed self-checking bench for regfile_sb (default parameters, 2 read ports).
module tb_regfile_sb;

  logic       clk = 1'b0;
  logic       rst;
  logic       ready;
  logic       wr_en;
  logic [2:0] wr_addr;
  logic [7:0] wr_data;
  logic       iss_en;
  logic [2:0] iss_addr;
  logic [5:0] rd_addr;
  logic [15:0] rd_data;
  logic [1:0] rd_busy;

  int checks   = 0;
  int failures = 0;
  int waited;

  regfile_sb dut (
    .clk      (clk),
    .rst      (rst),
    .ready    (ready),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .iss_en   (iss_en),
    .iss_addr (iss_addr),
    .rd_addr  (rd_addr),
    .rd_data  (rd_data),
    .rd_busy  (rd_busy)
  );

  always #5 clk = ~clk;

  // Advance one clock; inputs change #1 after the edge, away from sampling.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic we, input logic [2:0] wa, input logic [7:0] wd,
                               input logic ie, input logic [2:0] ia,
                               input logic [2:0] ra0, input logic [2:0] ra1);
    wr_en    = we;
    wr_addr  = wa;
    wr_data  = wd;
    iss_en   = ie;
    iss_addr = ia;
    rd_addr  = {ra1, ra0};
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1;
    applyStimulus(0, 0, 8'h00, 0, 0, 0, 0);
    tick();
    checkOutput("reset_ready", 32'(ready), 0);

    // Sweep with writes and issues that must be ignored.
    rst = 1'b0;
    for (int c = 1; c <= 4; c++) begin
      applyStimulus(1, 3'd0, 8'hFF, 1, 3'd1, 3'd0, 3'd1);
      checkOutput($sformatf("sweep_ready_c%0d", c), 32'(ready), 0);
      checkOutput($sformatf("sweep_data_c%0d", c), 32'(rd_data), 0);
      checkOutput($sformatf("sweep_busy_c%0d", c), 32'(rd_busy), 0);
      tick();
    end
    applyStimulus(0, 0, 8'h00, 0, 0, 3'd0, 3'd1);
    checkOutput("sweep_ready_c5", 32'(ready), 1);
    checkOutput("sweep_r0r1", 32'(rd_data), 0);
    checkOutput("sweep_busy_r0r1", 32'(rd_busy), 0);
    applyStimulus(0, 0, 8'h00, 0, 0, 3'd2, 3'd3);
    checkOutput("sweep_r2r3", 32'(rd_data), 0);

    // Write then read, and same-cycle forwarding.
    applyStimulus(1, 3'd2, 8'hA5, 0, 0, 3'd0, 3'd0);
    tick();
    applyStimulus(1, 3'd1, 8'h3C, 0, 0, 3'd2, 3'd1);
    checkOutput("read_r2", 32'(rd_data[7:0]), 32'hA5);
    checkOutput("fwd_r1", 32'(rd_data[15:8]), 32'h3C);
    tick();
    applyStimulus(0, 0, 8'h00, 0, 0, 3'd2, 3'd1);
    checkOutput("stored_r2r1", 32'(rd_data), 32'h3CA5);

    // Aliasing: address 6 maps onto R2.
    applyStimulus(1, 3'd6, 8'h77, 0, 0, 3'd0, 3'd0);
    tick();
    applyStimulus(0, 0, 8'h00, 0, 0, 3'd2, 3'd6);
    checkOutput("alias_r2", 32'(rd_data), 32'h7777);

    // Scoreboard.
    applyStimulus(0, 0, 8'h00, 1, 3'd3, 3'd3, 3'd3);
    checkOutput("iss_same_cycle", 32'(rd_busy), 0);
    tick();
    applyStimulus(0, 0, 8'h00, 0, 0, 3'd3, 3'd3);
    checkOutput("iss_busy_next", 32'(rd_busy), 32'b11);
    applyStimulus(1, 3'd3, 8'h11, 0, 0, 3'd3, 3'd2);
    checkOutput("wr_clears_fwd", 32'(rd_busy), 0);
    checkOutput("wr_fwd_data", 32'(rd_data), 32'h7711);
    tick();
    applyStimulus(0, 0, 8'h00, 0, 0, 3'd3, 3'd3);
    checkOutput("wr_cleared", 32'(rd_busy), 0);
    checkOutput("wr_r3", 32'(rd_data), 32'h1111);
    applyStimulus(1, 3'd3, 8'h22, 1, 3'd3, 3'd3, 3'd3);
    tick();
    applyStimulus(0, 0, 8'h00, 0, 0, 3'd3, 3'd0);
    checkOutput("iss_wr_data", 32'(rd_data[7:0]), 32'h22);
    checkOutput("iss_wr_busy", 32'(rd_busy), 32'b01);
    // A second issue to a busy register does not stack.
    applyStimulus(0, 0, 8'h00, 1, 3'd3, 3'd3, 3'd3);
    tick();
    applyStimulus(1, 3'd3, 8'h33, 0, 0, 3'd3, 3'd3);
    tick();
    applyStimulus(0, 0, 8'h00, 0, 0, 3'd3, 3'd3);
    checkOutput("no_counting", 32'(rd_busy), 0);

    // Mid-run reset.
    applyStimulus(1, 3'd0, 8'h01, 0, 0, 0, 0); tick();
    applyStimulus(1, 3'd1, 8'h02, 0, 0, 0, 0); tick();
    applyStimulus(1, 3'd2, 8'h03, 0, 0, 0, 0); tick();
    applyStimulus(1, 3'd3, 8'h04, 1, 3'd1, 0, 0); tick();
    applyStimulus(0, 0, 8'h00, 0, 0, 3'd1, 3'd2);
    checkOutput("pre_rst_busy", 32'(rd_busy), 32'b01);
    checkOutput("pre_rst_data", 32'(rd_data), 32'h0302);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    applyStimulus(0, 0, 8'h00, 0, 0, 3'd1, 3'd2);
    checkOutput("rst_ready_drop", 32'(ready), 0);
    checkOutput("rst_busy_clear", 32'(rd_busy), 0);
    waited = 0;
    while (!ready && waited < 20) begin
      tick();
      waited++;
    end
    checkOutput("resweep_cycles", 32'(waited), 4);
    applyStimulus(0, 0, 8'h00, 0, 0, 3'd0, 3'd1);
    checkOutput("post_rst_r0r1", 32'(rd_data), 0);
    checkOutput("post_rst_busy", 32'(rd_busy), 0);
    applyStimulus(0, 0, 8'h00, 0, 0, 3'd2, 3'd3);
    checkOutput("post_rst_r2r3", 32'(rd_data), 0);

    // Index 0 behaviour.
    applyStimulus(1, 3'd0, 8'hFF, 1, 3'd0, 3'd0, 3'd4);
`ifdef REGFILE_ZERO_REG_EN
    checkOutput("r0_fwd", 32'(rd_data), 0);
`else
    checkOutput("r0_fwd", 32'(rd_data), 32'hFFFF);
`endif
    tick();
    applyStimulus(0, 0, 8'h00, 0, 0, 3'd0, 3'd4);
`ifdef REGFILE_ZERO_REG_EN
    checkOutput("r0_data", 32'(rd_data), 0);
    checkOutput("r0_busy", 32'(rd_busy), 0);
`else
    checkOutput("r0_data", 32'(rd_data), 32'hFFFF);
    checkOutput("r0_busy", 32'(rd_busy), 32'b11);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("[TB] FAIL timeout observed=running expected=finished");
    $fatal(1, "[TB] timeout");
  end

endmodule
